crp16_alu_multiplier: RTL and testbench
=======================================

Name: crp16_alu_multiplier

Overview:
- Iterative 16x16 unsigned shift-and-add multiplier for the CRP16 ALU. Sits beside the ALU adder.
- Each cycle it drives a 16-bit add with carry-out (partial product high half + multiplicand) and consumes the sum and carry.
- Produces a 32-bit product after 16 iterations.
- Uses a start/busy/done handshake so the control unit can stall while the multiply runs.

Parameters:
- None. The datapath is fixed at the 16-bit CPU word; the product is 32 bits.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only when busy=0
- x  input  16  multiplicand; captured on an accepted start
- y  input  16  multiplier; captured on an accepted start
- busy  output  1  high while iterating; new starts are ignored
- done  output  1  one-cycle pulse when p_out becomes valid
- p_out  output  32  product; holds its value until the next completion
- ovf  output  1  high when p_out[31:16] != 0 (product does not fit in 16 bits); registered with p_out

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, p_out=0, ovf=0.
  - Internal registers are cleared: mcand, acc_hi, acc_lo, count=0.
  - Any in-flight multiply is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at an edge (accept edge E0):
  - mcand<=x, acc_hi<=0, acc_lo<=y, count<=0.
  - state<=RUN; busy<=1; done<=0.
  - p_out and ovf keep their old values.
- IDLE or DONE, start=0:
  - IDLE stays IDLE.
  - DONE moves to IDLE at the next edge; done returns to 0.
- RUN, at each edge E1..E16:
  - sum[16:0] = acc_lo[0] ? {1'b0,acc_hi}+{1'b0,mcand} : {1'b0,acc_hi}. The adder's carry-out is bit 16.
  - {acc_hi,acc_lo} <= {sum[16:0], acc_lo[15:1]}, i.e. a 33-bit value shifted right by one.
  - count <= count+1.
- The edge where count==15 (E16) completes the operation:
  - p_out <= the final {acc_hi,acc_lo}; ovf <= |final acc_hi.
  - state<=DONE; busy<=0; done<=1.
- Latency: done and the valid p_out are visible exactly 16 cycles after the accept edge. Throughput is one multiply per 16 cycles.
- start while busy=1 is ignored. No queuing, and operands are not re-captured.
- start=1 in DONE (the cycle done is high) is accepted; back-to-back issue gives one result every 16 cycles.
- x and y may change freely after the accept edge. Only the captured copies are used.
- count is 4 bits and wraps 15 -> 0 on the completion edge. No other wrap occurs.
- Carry-out of each add is never lost; it becomes bit 31 of the running product after the shift.
- Zero operands still take the full 16 cycles. There is no early termination.
- busy and done are never high in the same cycle.

Test Plan:
- Reset, then start with x=0x0003, y=0x0005 -> busy=1 for 16 cycles; done pulses 16 cycles after accept; p_out=0x0000000F, ovf=0.
- x=0xFFFF, y=0xFFFF -> p_out=0xFFFE0001, ovf=1. This checks carry-out propagation into bit 31 on every iteration.
- x=0x1234, y=0x0000, then x=0x0000, y=0xABCD -> p_out=0 both times, 16-cycle latency each; x=0x0100, y=0x0100 -> p_out=0x00010000, ovf=1.
- Start x=7, y=9; hold start=1 with x=2, y=2 during busy -> only one done, p_out=0x3F; a second start asserted in the done cycle returns p_out=0x4 sixteen cycles later.
- Start x=0x00FF, y=0x00FF; assert reset at cycle 8 of RUN -> busy, done, p_out, ovf clear immediately (asynchronously); no done pulse follows. A fresh start of 0x00FF*0x00FF then gives 0x0000FE01.
- Random 1000 operand pairs against a reference model -> p_out == x*y, ovf == (x*y > 0xFFFF), with the latency fixed at 16 cycles.

Source files
------------

// File: rtl/crp16_alu_multiplier.sv
// Iterative 16x16 unsigned shift-and-add multiplier for the CRP16 ALU.
// One add-and-shift per cycle; the 32-bit product is ready 16 cycles after a start is accepted.
module crp16_alu_multiplier (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] p_out,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [15:0] mcand;
    logic [15:0] acc_hi;
    logic [15:0] acc_lo;
    logic [3:0]  count;
    logic [16:0] sum;

    // The adder's carry-out lands in sum[16] and becomes the top bit after the shift.
    always_comb begin
        sum = {1'b0, acc_hi};
        if (acc_lo[0]) begin
            sum = {1'b0, acc_hi} + {1'b0, mcand};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            p_out  <= 32'd0;
            ovf    <= 1'b0;
            mcand  <= 16'd0;
            acc_hi <= 16'd0;
            acc_lo <= 16'd0;
            count  <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= x;
                        acc_hi <= 16'd0;
                        acc_lo <= y;
                        count  <= 4'd0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi <= sum[16:1];
                    acc_lo <= {sum[0], acc_lo[15:1]};
                    count  <= count + 4'd1;
                    // Last iteration: publish the shifted 33-bit value as the product.
                    if (count == 4'd15) begin
                        p_out <= {sum[16:0], acc_lo[15:1]};
                        ovf   <= |sum[16:1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crp16_alu_multiplier.sv
// Directed and random checks of the iterative multiplier: latency, handshake, reset and products.
module tb_crp16_alu_multiplier;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [31:0] p_out;
    logic        ovf;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] last_p;
    logic        last_ovf;

    crp16_alu_multiplier dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .p_out (p_out),
        .ovf   (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one multiply from a negedge and follow it through all 16 cycles.
    // With hold set, start stays high with new operands, which must be ignored while busy.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic hold, input logic [15:0] a2, input logic [15:0] b2,
                                  input logic [31:0] exp_p, input string tag);
        logic exp_ovf;
        exp_ovf = (exp_p[31:16] != 16'd0);
        start = 1'b1;
        x     = a;
        y     = b;
        @(posedge clock);
        @(negedge clock);
        if (hold) begin
            x = a2;
            y = b2;
        end else begin
            start = 1'b0;
            x     = 16'($urandom);
            y     = 16'($urandom);
        end
        check_output({tag, " busy after accept"}, busy, 1'b1);
        check_output({tag, " done after accept"}, done, 1'b0);
        check_output({tag, " p_out holds"}, p_out, last_p);
        check_output({tag, " ovf holds"}, ovf, last_ovf);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_output({tag, " busy"}, busy, (i != 16));
            check_output({tag, " done"}, done, (i == 16));
        end
        check_output({tag, " p_out"}, p_out, exp_p);
        check_output({tag, " ovf"}, ovf, exp_ovf);
        last_p   = exp_p;
        last_ovf = exp_ovf;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] rp;

        reset    = 1'b1;
        start    = 1'b0;
        x        = 16'd0;
        y        = 16'd0;
        last_p   = 32'd0;
        last_ovf = 1'b0;
        repeat (2) @(negedge clock);
        check_output("reset busy", busy, 1'b0);
        check_output("reset done", done, 1'b0);
        check_output("reset p_out", p_out, 32'd0);
        check_output("reset ovf", ovf, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        apply_stimulus(16'h0003, 16'h0005, 1'b0, 16'h0, 16'h0, 32'h0000000F, "3x5");
        // DONE returns to IDLE with start low; result is held.
        @(negedge clock);
        check_output("idle done", done, 1'b0);
        check_output("idle busy", busy, 1'b0);
        check_output("idle p_out", p_out, 32'h0000000F);

        apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 16'h0, 32'hFFFE0001, "ffff^2");
        apply_stimulus(16'h1234, 16'h0000, 1'b0, 16'h0, 16'h0, 32'h00000000, "y0");
        apply_stimulus(16'h0000, 16'hABCD, 1'b0, 16'h0, 16'h0, 32'h00000000, "x0");
        apply_stimulus(16'h0100, 16'h0100, 1'b0, 16'h0, 16'h0, 32'h00010000, "100^2");

        // Start held high during busy; it is re-accepted only in the done cycle.
        apply_stimulus(16'h0007, 16'h0009, 1'b1, 16'h0002, 16'h0002, 32'h0000003F, "7x9 held");
        apply_stimulus(16'h0002, 16'h0002, 1'b0, 16'h0, 16'h0, 32'h00000004, "2x2 b2b");
        @(negedge clock);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        x     = 16'h00FF;
        y     = 16'h00FF;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_output("async busy", busy, 1'b0);
        check_output("async done", done, 1'b0);
        check_output("async p_out", p_out, 32'd0);
        check_output("async ovf", ovf, 1'b0);
        @(negedge clock);
        reset    = 1'b0;
        last_p   = 32'd0;
        last_ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_output("no done after reset", done, 1'b0);
        end
        apply_stimulus(16'h00FF, 16'h00FF, 1'b0, 16'h0, 16'h0, 32'h0000FE01, "ff^2 fresh");

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rp = {16'd0, ra} * {16'd0, rb};
            apply_stimulus(ra, rb, 1'b0, 16'h0, 16'h0, rp, "random");
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
